// File: rtl/transport_tx_buffer_if.sv
// Handshake bundle between transport layer, tx buffer and lane adapter.
// slave = buffer side, master = upstream/lane side.
interface transport_tx_buffer_if #(
  parameter int DEPTH = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          cl0_s;
  logic          transport_data_flag;
  logic [7:0]    transport_layer_data_in;
  logic          tl_ready;
  logic          lane_rd_en;
  logic [7:0]    lane_data_out;
  logic          lane_data_valid;
  logic [LW-1:0] fifo_level;
  logic          almost_full;
  logic          overflow;
  logic          underflow;

  modport slave (
    input  cl0_s,
    input  transport_data_flag,
    input  transport_layer_data_in,
    input  lane_rd_en,
    output tl_ready,
    output lane_data_out,
    output lane_data_valid,
    output fifo_level,
    output almost_full,
    output overflow,
    output underflow
  );

  modport master (
    output cl0_s,
    output transport_data_flag,
    output transport_layer_data_in,
    output lane_rd_en,
    input  tl_ready,
    input  lane_data_out,
    input  lane_data_valid,
    input  fifo_level,
    input  almost_full,
    input  overflow,
    input  underflow
  );
endinterface

// File: rtl/transport_tx_buffer.sv
// Transport-to-lane byte FIFO with CL0 gating and drain-on-exit.
// Occupancy counter, not pointer equality, separates full from empty.
module transport_tx_buffer #(
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = 12
) (
  input logic                   clk,
  input logic                   reset,
  transport_tx_buffer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    DISABLED,
    ACTIVE,
    DRAIN
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic [7:0]    r_mem [DEPTH];
  logic [7:0]    r_dout;
  logic          r_valid;
  logic          r_ovf;
  logic          r_unf;

  logic          w_full;
  logic          w_empty;
  logic          w_ready;
  logic          w_wr;
  logic          w_rd;
  logic [LW-1:0] w_level_nxt;

  assign w_full  = (r_level == LW'(DEPTH));
  assign w_empty = (r_level == '0);
  assign w_ready = (r_state == ACTIVE) && !w_full;
  assign w_wr    = bus.transport_data_flag && w_ready;
  assign w_rd    = bus.lane_rd_en && !w_empty
                && (r_state != DISABLED);

  always_comb begin
    w_level_nxt = r_level;
    case ({w_wr, w_rd})
      2'b10:   w_level_nxt = r_level + 1'b1;
      2'b01:   w_level_nxt = r_level - 1'b1;
      default: w_level_nxt = r_level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[r_wptr] <= bus.transport_layer_data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= DISABLED;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_dout  <= 8'h00;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_valid <= w_rd;
      r_level <= w_level_nxt;
      if (w_rd) begin
        r_dout <= r_mem[r_rptr];
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_wr)
        r_wptr <= r_wptr + 1'b1;
      if (bus.lane_rd_en && w_empty)
        r_unf <= 1'b1;
      if ((r_state == ACTIVE) && w_full
          && bus.transport_data_flag)
        r_ovf <= 1'b1;
      unique case (r_state)
        DISABLED: begin
          r_wptr <= '0;
          r_rptr <= '0;
          r_level <= '0;
          if (bus.cl0_s)
            r_state <= ACTIVE;
        end
        ACTIVE: begin
          if (!bus.cl0_s)
            r_state <= DRAIN;
        end
        DRAIN: begin
          if (bus.cl0_s) begin
            r_state <= ACTIVE;
          end else if (w_level_nxt == '0) begin
            // fully drained: rewind pointers so the buffer restarts clean
            r_state <= DISABLED;
            r_wptr  <= '0;
            r_rptr  <= '0;
          end
        end
        default: r_state <= DISABLED;
      endcase
    end
  end

  assign bus.tl_ready        = w_ready;
  assign bus.lane_data_out   = r_dout;
  assign bus.lane_data_valid = r_valid;
  assign bus.fifo_level      = r_level;
  assign bus.almost_full     = (r_level >= LW'(AFULL_LEVEL));
  assign bus.overflow        = r_ovf;
  assign bus.underflow       = r_unf;
endmodule

// File: tb/tb_transport_tx_buffer.sv
// Directed bench for transport_tx_buffer: vector table plus
// hand-written fill, wrap, drain and reset sequences.
module tb_transport_tx_buffer;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  transport_tx_buffer_if #(.DEPTH(16)) bus ();

  transport_tx_buffer #(
    .DEPTH(16),
    .AFULL_LEVEL(12)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       cl0;
    logic       flg;
    logic [7:0] din;
    logic       rd;
    logic       rdy;
    logic       vld;
    logic [7:0] dout;
    logic [4:0] lvl;
    logic       unf;
  } vec_t;

  vec_t tv [10];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic cl0, input logic flg,
                       input logic [7:0] din, input logic rd);
    bus.cl0_s                   = cl0;
    bus.transport_data_flag     = flg;
    bus.transport_layer_data_in = din;
    bus.lane_rd_en              = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0);

    tv[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};
    tv[1] = '{1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 5'd1, 1'b0};
    tv[2] = '{1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'h00, 5'd2, 1'b0};
    tv[3] = '{1'b1, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 8'h00, 5'd3, 1'b0};
    tv[4] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11, 5'd2, 1'b0};
    tv[5] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 5'd1, 1'b0};
    tv[6] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 5'd0, 1'b0};
    tv[7] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h33, 5'd0, 1'b0};
    tv[8] = '{1'b1, 1'b1, 8'h5C, 1'b1, 1'b1, 1'b0, 8'h33, 5'd1, 1'b1};
    tv[9] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h5C, 5'd0, 1'b1};

    do_reset();
    chk("rst_ready", bus.tl_ready, 0);
    chk("rst_dout", bus.lane_data_out, 8'h00);
    chk("rst_valid", bus.lane_data_valid, 0);
    chk("rst_level", bus.fifo_level, 0);
    chk("rst_afull", bus.almost_full, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_unf", bus.underflow, 0);

    for (int i = 0; i < 10; i++) begin
      drive(tv[i].cl0, tv[i].flg, tv[i].din, tv[i].rd);
      chk($sformatf("v%0d_ready", i), bus.tl_ready, tv[i].rdy);
      tick();
      chk($sformatf("v%0d_valid", i), bus.lane_data_valid, tv[i].vld);
      chk($sformatf("v%0d_dout", i), bus.lane_data_out, tv[i].dout);
      chk($sformatf("v%0d_level", i), bus.fifo_level, tv[i].lvl);
      chk($sformatf("v%0d_unf", i), bus.underflow, tv[i].unf);
      chk($sformatf("v%0d_ovf", i), bus.overflow, 0);
    end

    // fill to full, then overflow with a simultaneous read
    do_reset();
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 8'(i), 1'b0);
      chk($sformatf("fill%0d_ready", i), bus.tl_ready, 1);
      tick();
      chk($sformatf("fill%0d_level", i), bus.fifo_level, i + 1);
      chk($sformatf("fill%0d_afull", i), bus.almost_full,
          (i + 1 >= 12) ? 1 : 0);
    end
    drive(1'b1, 1'b1, 8'hAA, 1'b1);
    chk("full_ready", bus.tl_ready, 0);
    chk("full_ovf_pre", bus.overflow, 0);
    tick();
    chk("ovf_set", bus.overflow, 1);
    chk("ovf_level", bus.fifo_level, 15);
    chk("ovf_valid", bus.lane_data_valid, 1);
    chk("ovf_dout", bus.lane_data_out, 8'h00);
    for (int i = 1; i < 16; i++) begin
      drive(1'b1, 1'b0, 8'h00, 1'b1);
      tick();
      chk($sformatf("flush%0d_dout", i), bus.lane_data_out, i);
    end
    chk("flush_level", bus.fifo_level, 0);

    // sustained write+read across several pointer wraps
    do_reset();
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b1, 8'(8'h40 + k), 1'b0);
      tick();
    end
    for (int k = 0; k < 40; k++) begin
      drive(1'b1, 1'b1, 8'(8'h45 + k), 1'b1);
      tick();
      chk($sformatf("wrap%0d_level", k), bus.fifo_level, 5);
      chk($sformatf("wrap%0d_valid", k), bus.lane_data_valid, 1);
      chk($sformatf("wrap%0d_dout", k), bus.lane_data_out, 8'h40 + k);
    end
    chk("wrap_ovf", bus.overflow, 0);
    chk("wrap_unf", bus.underflow, 0);

    // drain on CL0 exit, re-entry with 2 left, then drain to disabled
    do_reset();
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 8'(8'hA0 + k), 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    drive(1'b0, 1'b1, 8'hEE, 1'b1);
    chk("drain_ready", bus.tl_ready, 0);
    tick();
    chk("drain0_dout", bus.lane_data_out, 8'hA0);
    chk("drain0_level", bus.fifo_level, 3);
    chk("drain0_ovf", bus.overflow, 0);
    drive(1'b0, 1'b1, 8'hEF, 1'b1);
    tick();
    chk("drain1_dout", bus.lane_data_out, 8'hA1);
    chk("drain1_level", bus.fifo_level, 2);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    chk("reent_level", bus.fifo_level, 2);
    chk("reent_ready", bus.tl_ready, 1);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    chk("drain2_dout", bus.lane_data_out, 8'hA2);
    tick();
    chk("drain3_dout", bus.lane_data_out, 8'hA3);
    chk("drain3_level", bus.fifo_level, 0);
    drive(1'b0, 1'b1, 8'h77, 1'b0);
    chk("dis_ready", bus.tl_ready, 0);
    tick();
    chk("dis_level", bus.fifo_level, 0);
    chk("dis_ovf", bus.overflow, 0);
    chk("dis_unf", bus.underflow, 0);

    // reset pulsed at level 7 clears data and sticky flags
    do_reset();
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    tick();
    chk("pre_unf", bus.underflow, 1);
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, 1'b1, 8'(8'h60 + k), 1'b0);
      tick();
    end
    chk("pre_level", bus.fifo_level, 7);
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    chk("mid_level", bus.fifo_level, 0);
    chk("mid_valid", bus.lane_data_valid, 0);
    chk("mid_unf", bus.underflow, 0);
    chk("mid_ovf", bus.overflow, 0);
    chk("mid_ready", bus.tl_ready, 0);
    tick();
    chk("mid_ready_back", bus.tl_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
